// File: rtl/cbd_poly_writer.sv
// Reduces cbd coefficient beats to canonical mod-q values and writes one
// 256-coefficient polynomial (64 packed words) into the NTT polynomial RAM.
module cbd_poly_writer #(
    parameter int unsigned Q      = 3329,
    parameter int unsigned CW     = 12,
    parameter int unsigned NBEAT  = 16,
    parameter int unsigned PSEL_W = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [PSEL_W-1:0]     i_poly_sel,
    input  logic [47:0]           i_coeffs,
    input  logic                  i_coeffs_valid,
    output logic                  o_coeffs_ready,
    output logic                  o_wr_en,
    output logic [PSEL_W+5:0]     o_wr_addr,
    output logic [4*CW-1:0]       o_wr_data,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int unsigned NCOEF = 16;
    localparam int unsigned BW    = $clog2(NBEAT);
    localparam int unsigned AW    = PSEL_W + 6;
    localparam int unsigned DW    = 4 * CW;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEAT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
    typedef logic [NCOEF-1:0][CW-1:0] coef_buf_t;

    // Negative codes map to Q+x; the sign-extended add wraps modulo 2^CW.
    function automatic logic [CW-1:0] reduce(input logic [2:0] x);
        logic [CW-1:0] r;
        if (x[2]) r = CW'(Q) + {{(CW-3){1'b1}}, x};
        else      r = CW'(x);
        return r;
    endfunction

    function automatic coef_buf_t reduce_beat(input logic [47:0] c);
        coef_buf_t r;
        for (int k = 0; k < NCOEF; k++) r[k] = reduce(c[3*k +: 3]);
        return r;
    endfunction

    function automatic logic [DW-1:0] pick_word(input coef_buf_t b, input logic [1:0] s);
        logic [DW-1:0] r;
        for (int j = 0; j < 4; j++) r[CW*j +: CW] = b[4*int'(s) + j];
        return r;
    endfunction

    function automatic logic [AW-1:0] make_addr(input logic [PSEL_W-1:0] ps,
                                                input logic [BW-1:0] bt,
                                                input logic [1:0] s);
        return {ps, 6'({bt, s})};
    endfunction

    state_t              state_q, state_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [1:0]          sub_q, sub_d;
    logic [PSEL_W-1:0]   psel_q, psel_d;
    coef_buf_t           buf_q, buf_d;
    coef_buf_t           beat_red;

    logic                ready_d, wr_en_d, busy_d, done_d;
    logic [AW-1:0]       wr_addr_d;
    logic [DW-1:0]       wr_data_d;
    logic                accept;

    assign beat_red = reduce_beat(i_coeffs);
    assign accept   = i_coeffs_valid & o_coeffs_ready;

    // State, counters, buffer and all outputs are registered together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q        <= IDLE;
            beat_q         <= '0;
            sub_q          <= '0;
            psel_q         <= '0;
            buf_q          <= '0;
            o_coeffs_ready <= 1'b0;
            o_wr_en        <= 1'b0;
            o_wr_addr      <= '0;
            o_wr_data      <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            sub_q          <= sub_d;
            psel_q         <= psel_d;
            buf_q          <= buf_d;
            o_coeffs_ready <= ready_d;
            o_wr_en        <= wr_en_d;
            o_wr_addr      <= wr_addr_d;
            o_wr_data      <= wr_data_d;
            o_busy         <= busy_d;
            o_done         <= done_d;
        end
    end

    // The first word of a beat is written straight from the reduced input,
    // so a beat taken at sub=3 follows the previous word without a bubble.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        sub_d     = sub_q;
        psel_d    = psel_q;
        buf_d     = buf_q;
        ready_d   = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = o_wr_addr;
        wr_data_d = o_wr_data;
        busy_d    = o_busy;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = LOAD;
                    psel_d  = i_poly_sel;
                    beat_d  = '0;
                    sub_d   = '0;
                    busy_d  = 1'b1;
                    ready_d = 1'b1;
                end
            end
            LOAD: begin
                ready_d = 1'b1;
                if (accept) begin
                    state_d   = DRAIN;
                    buf_d     = beat_red;
                    sub_d     = '0;
                    ready_d   = 1'b0;
                    wr_en_d   = 1'b1;
                    wr_addr_d = make_addr(psel_q, beat_q, 2'd0);
                    wr_data_d = pick_word(beat_red, 2'd0);
                end
            end
            DRAIN: begin
                if (sub_q != 2'd3) begin
                    sub_d     = sub_q + 2'd1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = make_addr(psel_q, beat_q, sub_q + 2'd1);
                    wr_data_d = pick_word(buf_q, sub_q + 2'd1);
                    ready_d   = (sub_q == 2'd2) && (beat_q != LAST_BEAT);
                end else if (beat_q == LAST_BEAT) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    beat_d = BW'(beat_q + 1'b1);
                    if (accept) begin
                        buf_d     = beat_red;
                        sub_d     = '0;
                        wr_en_d   = 1'b1;
                        wr_addr_d = make_addr(psel_q, BW'(beat_q + 1'b1), 2'd0);
                        wr_data_d = pick_word(beat_red, 2'd0);
                    end else begin
                        state_d = LOAD;
                        ready_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cbd_poly_writer.sv
// Randomized bench for cbd_poly_writer: drives beats, records every RAM write
// and checks it against an array model of the reduced, packed polynomial.
module tb_cbd_poly_writer;

    localparam int Q = 3329;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [1:0]  i_poly_sel;
    logic [47:0] i_coeffs;
    logic        i_coeffs_valid;
    logic        o_coeffs_ready;
    logic        o_wr_en;
    logic [7:0]  o_wr_addr;
    logic [47:0] o_wr_data;
    logic        o_busy;
    logic        o_done;

    cbd_poly_writer dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_poly_sel     (i_poly_sel),
        .i_coeffs       (i_coeffs),
        .i_coeffs_valid (i_coeffs_valid),
        .o_coeffs_ready (o_coeffs_ready),
        .o_wr_en        (o_wr_en),
        .o_wr_addr      (o_wr_addr),
        .o_wr_data      (o_wr_data),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0]  mon_addr[$];
    logic [47:0] mon_data[$];
    int          mon_cyc[$];
    int          done_cnt;
    int          done_cyc;
    logic [47:0] beats[16];
    int          acc[16];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_wr_en) begin
            mon_addr.push_back(o_wr_addr);
            mon_data.push_back(o_wr_data);
            mon_cyc.push_back(cyc);
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Reference: flatten the beats to 256 signed values, map to [0,Q), pack by 4.
    function automatic logic [47:0] model_word(input int w);
        int coef[256];
        logic [47:0] r;
        logic [47:0] bt;
        logic [2:0] code;
        int v;
        for (int b = 0; b < 16; b++) begin
            bt = beats[b];
            for (int k = 0; k < 16; k++) begin
                code = bt[3*k +: 3];
                v = code[2] ? int'(code) - 8 : int'(code);
                coef[16*b + k] = (v < 0) ? Q + v : v;
            end
        end
        r = '0;
        for (int j = 0; j < 4; j++) r[12*j +: 12] = 12'(coef[4*w + j]);
        return r;
    endfunction

    task automatic clear_mon();
        mon_addr.delete();
        mon_data.delete();
        mon_cyc.delete();
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic pulse_start(input logic [1:0] ps);
        i_start = 1'b1;
        i_poly_sel = ps;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic send_beat(input logic [47:0] d, input bit extra_start, output int a);
        i_coeffs = d;
        i_coeffs_valid = 1'b1;
        if (extra_start) begin
            i_start = 1'b1;
            i_poly_sel = 2'd1;
        end
        a = -1;
        for (int k = 0; k < 300 && a < 0; k++) begin
            if (o_coeffs_ready) begin
                @(negedge clk);
                a = cyc;
            end else begin
                @(negedge clk);
            end
            i_start = 1'b0;
        end
        if (a < 0) check("beat_accept_timeout", 64'(0), 64'(1));
    endtask

    // mode 0: streaming, 1: 5-cycle producer stall before beat 4, 2: start while busy
    task automatic run_poly(input logic [1:0] ps, input int mode, input string name);
        int a;
        int n;
        clear_mon();
        pulse_start(ps);
        check({name, "_busy"}, 64'(o_busy), 64'(1));
        for (int b = 0; b < 16; b++) begin
            if (mode == 1 && b == 4) begin
                i_coeffs_valid = 1'b0;
                for (int k = 0; k < 50 && !o_coeffs_ready; k++) @(negedge clk);
                repeat (5) @(negedge clk);
            end
            send_beat(beats[b], (mode == 2) && (b == 8), a);
            acc[b] = a;
        end
        i_coeffs_valid = 1'b0;
        for (int k = 0; k < 400 && done_cnt == 0; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        #1;
        n = mon_addr.size();
        check({name, "_nwrites"}, 64'(n), 64'(64));
        if (n == 64) begin
            for (int w = 0; w < 64; w++) begin
                check($sformatf("%s_addr%0d", name, w), 64'(mon_addr[w]), 64'({ps, 6'(w)}));
                check($sformatf("%s_data%0d", name, w), 64'(mon_data[w]), 64'(model_word(w)));
            end
            check({name, "_latency"}, 64'(mon_cyc[0]), 64'(acc[0]));
            check({name, "_done_after_last"}, 64'(done_cyc), 64'(mon_cyc[63] + 1));
            if (mode == 1) begin
                check({name, "_gap"}, 64'(mon_cyc[16] - mon_cyc[15]), 64'(6));
                check({name, "_span"}, 64'(mon_cyc[63] - mon_cyc[0]), 64'(68));
            end else begin
                check({name, "_contig"}, 64'(mon_cyc[63] - mon_cyc[0]), 64'(63));
                check({name, "_done_from_accept"}, 64'(done_cyc - acc[0]), 64'(64));
                for (int b = 1; b < 16; b++)
                    check($sformatf("%s_acc_step%0d", name, b), 64'(acc[b] - acc[b-1]), 64'(4));
            end
        end
        check({name, "_done_cnt"}, 64'(done_cnt), 64'(1));
        check({name, "_busy_end"}, 64'(o_busy), 64'(0));
    endtask

    task automatic rand_beats();
        for (int b = 0; b < 16; b++) beats[b] = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_ready"}, 64'(o_coeffs_ready), 64'(0));
        check({name, "_wr_en"}, 64'(o_wr_en), 64'(0));
        check({name, "_addr"},  64'(o_wr_addr), 64'(0));
        check({name, "_data"},  64'(o_wr_data), 64'(0));
        check({name, "_busy"},  64'(o_busy), 64'(0));
        check({name, "_done"},  64'(o_done), 64'(0));
    endtask

    initial begin
        int a;
        int n;
        i_rst = 1'b1;
        i_start = 1'b0;
        i_poly_sel = 2'd0;
        i_coeffs = '0;
        i_coeffs_valid = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        i_rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int b = 0; b < 16; b++) beats[b] = '0;
        run_poly(2'd2, 0, "zero");

        rand_beats();
        beats[0] = {24'h0, 3'd4, 3'd5, 3'd6, 3'd7, 3'd3, 3'd2, 3'd1, 3'd0};
        run_poly(2'd0, 0, "sign");
        if (mon_data.size() >= 2) begin
            check("sign_word0_const", 64'(mon_data[0]), 64'(48'h003_002_001_000));
            check("sign_word1_const", 64'(mon_data[1]), 64'(48'hCFD_CFE_CFF_D00));
        end else begin
            check("sign_words_present", 64'(mon_data.size()), 64'(2));
        end

        rand_beats();
        run_poly(2'd3, 0, "rand");

        rand_beats();
        run_poly(2'd1, 1, "stall");

        rand_beats();
        run_poly(2'd2, 2, "busy_start");

        // Reset in the middle of a polynomial, then a clean full polynomial.
        rand_beats();
        clear_mon();
        pulse_start(2'd3);
        for (int b = 0; b < 6; b++) send_beat(beats[b], 1'b0, a);
        @(negedge clk);
        i_rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        n = mon_addr.size();
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        i_coeffs_valid = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("midrst_no_writes", 64'(mon_addr.size()), 64'(n));
        check("midrst_no_done", 64'(done_cnt), 64'(0));
        check("midrst_words_before", 64'(n >= 21), 64'(1));
        i_coeffs_valid = 1'b0;
        @(negedge clk);

        rand_beats();
        run_poly(2'd1, 0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cbd_poly_writer.md
Name: cbd_poly_writer

Overview:
- Downstream of cbd. Consumes the 48-bit coefficient beats from cbd: 16 coefficients per beat, 3-bit two's complement each.
- Reduces each coefficient to its canonical mod-q 12-bit value.
- Packs 4 coefficients per 48-bit word and writes one 256-coefficient polynomial (64 words) into the polynomial RAM that feeds the NTT.
- One start, one polynomial, one done pulse.

Parameters:
- Q, 3329, Kyber modulus used for negative-value correction.
- CW, 12, output coefficient width in bits.
- NBEAT, 16, input beats per polynomial (16 beats x 16 coeffs = 256).
- PSEL_W, 2, polynomial-slot select width (upper RAM address bits).

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle pulse; arms the block for one polynomial. Ignored unless IDLE.
- i_poly_sel  in  PSEL_W  target polynomial slot; latched on an accepted i_start.
- i_coeffs  in  48  16 coefficients; coeff k occupies bits [3k+2:3k], k=0 at LSBs.
- i_coeffs_valid  in  1  input beat valid.
- o_coeffs_ready  out  1  block can accept a beat this cycle.
- o_wr_en  out  1  RAM write strobe.
- o_wr_addr  out  PSEL_W+6  {poly_sel, word_idx[5:0]}.
- o_wr_data  out  4*CW  4 coefficients; coeff 4w+j at bits [12j+11:12j].
- o_busy  out  1  high from accepted start until done.
- o_done  out  1  one-cycle pulse after the last RAM write.

Behaviour:
- Reset values: o_coeffs_ready=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_busy=0, o_done=0. State=IDLE; beat counter and sub-word counter=0; coefficient buffer cleared.
- States:
  - IDLE: i_start -> LOAD, latch i_poly_sel, clear counters, o_busy=1.
  - LOAD: o_coeffs_ready=1. Valid&ready -> capture all 16 reduced coeffs into the buffer -> DRAIN, sub=0.
  - DRAIN: one write per cycle, sub=0..3. The write at sub=s carries coeffs 4s..4s+3 of the buffer, word_idx = 4*beat+s.
  - After sub=3: if beat==NBEAT-1 -> DONE, else beat+1 and the next beat may be taken.
  - DONE: o_done=1 for exactly one cycle, o_busy=0 -> IDLE.
- Back-to-back: in DRAIN with sub=3 and beat<NBEAT-1, o_coeffs_ready=1. A beat accepted there is captured at the same edge the sub=3 write completes, so the stream continues without a bubble. The ideal poly is 64 consecutive write cycles.
- Latency: beat accepted at edge t -> o_wr_en high in cycles t+1..t+4 (registered outputs). Last write at cycle T -> o_done at T+1.
- Reduction (combinational on capture): 3-bit signed x. x>=0 -> x zero-extended to 12 bits. x<0 -> Q+x (-1->3328, -2->3327, -3->3326). Code 3'b100 (-4, outside eta<=3) maps to 3325; no error flag.
- o_coeffs_ready=0 in IDLE, in DONE, and in DRAIN with sub 0..2. Input valid while not ready is ignored; no data is lost from the producer, which holds the beat.
- o_wr_data/o_wr_addr hold their last value when o_wr_en=0. Only o_wr_en qualifies them.
- i_start while busy: ignored; latched i_poly_sel unchanged.
- i_start in the same cycle as o_done: ignored (state is DONE); it must be reissued in IDLE.
- Producer stall (valid low in LOAD or at sub=3): block waits indefinitely. No timeout; o_wr_en stays 0.
- Reset mid-operation: immediate return to IDLE with reset values. The partial polynomial is not completed and no further writes occur.

Test Plan:
- All-zero: start with poly_sel=2, 16 beats of 48'h0 -> 64 writes, addr 8'h80..8'hBF, data all 0, o_done once, one cycle after addr 8'hBF.
- Sign mapping: beat with coeffs 0..7 = {0,1,2,3,-1,-2,-3,-4}, rest 0 -> word 0 data {3,2,1,0} packed = 48'h003_002_001_000; word 1 = {3325,3326,3327,3328} = 48'hCFD_CFE_CFF_D00 (coeff 7 at MSBs).
- Back-to-back streaming: valid held high for all 16 beats -> o_coeffs_ready pulses at 16 accept points, o_wr_en high 64 consecutive cycles, o_done 65 cycles after first accept.
- Stalled producer: valid deasserted 5 cycles between beats 3 and 4 -> write stream gaps 5 cycles after word 15, word 16 carries beat 4 data, total writes still 64.
- Start while busy: second i_start with poly_sel=1 at beat 8 -> ignored, all addresses keep the first poly_sel, single o_done.
- Reset mid-poly: assert i_rst after word 20 -> outputs at reset values same cycle, no further o_wr_en, no o_done; a new start afterwards writes a full 64 words from word 0.
